// File: rtl/panel_scan_driver.sv
// LED panel scan driver: double-buffered 2x256x32 frame store fed by chunk writes,
// front bank shifted out row by row with latch and output-enable sequencing.
module panel_scan_driver #(
    parameter int unsigned PANEL_ID     = 0,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned LATCH_CYCLES = 2,
    parameter int unsigned ON_CYCLES    = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] chunk_data,
    input  logic [3:0]  chunk_addr,
    input  logic        chunk_write_enable,
    input  logic [3:0]  row_addr,
    input  logic [1:0]  panel_addr,
    output logic        sclk,
    output logic        sdata,
    output logic        latch,
    output logic        oe_n,
    output logic [3:0]  row_sel,
    output logic        frame_swapped
);

    localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
    localparam logic [15:0] LatchLast = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0] OnLast    = 16'(ON_CYCLES - 1);

    typedef enum logic [2:0] {StRead, StLoad, StShiftLo, StShiftHi, StLatch, StDisplay} state_e;

    state_e      state;
    logic [3:0]  row;
    logic [3:0]  chunk;
    logic [4:0]  bit_idx;
    logic [15:0] cnt;
    logic [31:0] shreg;
    logic [31:0] rd_data;
    logic        front_sel;
    logic        swap_pending;

    logic [31:0] bank0 [256];
    logic [31:0] bank1 [256];

    logic       wr_accept;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic       swap_hold;

    assign wr_accept = chunk_write_enable && (panel_addr == 2'(PANEL_ID));
    assign wr_addr   = {row_addr, chunk_addr};
    assign rd_addr   = {row, chunk};
    // A write landing on the swap cycle holds DISPLAY so no write straddles a bank change.
    assign swap_hold = (row == 4'd15) && swap_pending && wr_accept;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (front_sel) begin
                bank0[wr_addr] <= chunk_data;
            end else begin
                bank1[wr_addr] <= chunk_data;
            end
        end
        rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StRead;
            row           <= 4'd0;
            chunk         <= 4'd0;
            bit_idx       <= 5'd0;
            cnt           <= 16'd0;
            shreg         <= 32'd0;
            sclk          <= 1'b0;
            sdata         <= 1'b0;
            latch         <= 1'b0;
            oe_n          <= 1'b1;
            row_sel       <= 4'd0;
            frame_swapped <= 1'b0;
            front_sel     <= 1'b0;
            swap_pending  <= 1'b0;
        end else begin
            frame_swapped <= 1'b0;
            if (wr_accept && wr_addr == 8'hFF) begin
                swap_pending <= 1'b1;
            end
            unique case (state)
                StRead: state <= StLoad;
                StLoad: begin
                    shreg   <= rd_data;
                    sdata   <= rd_data[31];
                    bit_idx <= 5'd0;
                    cnt     <= 16'd0;
                    sclk    <= 1'b0;
                    state   <= StShiftLo;
                end
                StShiftLo: begin
                    if (cnt == DivLast) begin
                        cnt   <= 16'd0;
                        sclk  <= 1'b1;
                        state <= StShiftHi;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StShiftHi: begin
                    if (cnt == DivLast) begin
                        cnt     <= 16'd0;
                        sclk    <= 1'b0;
                        shreg   <= {shreg[30:0], 1'b0};
                        bit_idx <= bit_idx + 5'd1;
                        if (bit_idx == 5'd31) begin
                            if (chunk == 4'd15) begin
                                chunk   <= 4'd0;
                                latch   <= 1'b1;
                                row_sel <= row;
                                state   <= StLatch;
                            end else begin
                                chunk <= chunk + 4'd1;
                                state <= StRead;
                            end
                        end else begin
                            sdata <= shreg[30];
                            state <= StShiftLo;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StLatch: begin
                    if (cnt == LatchLast) begin
                        cnt   <= 16'd0;
                        latch <= 1'b0;
                        oe_n  <= 1'b0;
                        state <= StDisplay;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StDisplay: begin
                    if (cnt == OnLast) begin
                        if (!swap_hold) begin
                            cnt   <= 16'd0;
                            oe_n  <= 1'b1;
                            row   <= row + 4'd1;
                            state <= StRead;
                            if (row == 4'd15 && swap_pending) begin
                                front_sel     <= ~front_sel;
                                swap_pending  <= 1'b0;
                                frame_swapped <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= StRead;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_scan_driver.sv
// Bench for panel_scan_driver: random frame writes checked against a cycle-position
// model of the scan (row/phase arithmetic) plus scenario-specific checks.
module tb_panel_scan_driver;

    localparam int D   = 1;
    localparam int L   = 2;
    localparam int O   = 16;
    localparam int PID = 0;
    localparam int C   = 2 + 64 * D;
    localparam int R   = 16 * C + L + O;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_addr;
    logic        chunk_write_enable;
    logic [3:0]  row_addr;
    logic [1:0]  panel_addr;
    logic        sclk, sdata, latch, oe_n, frame_swapped;
    logic [3:0]  row_sel;

    panel_scan_driver #(
        .PANEL_ID(PID), .CLK_DIV(D), .LATCH_CYCLES(L), .ON_CYCLES(O)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chunk_data(chunk_data), .chunk_addr(chunk_addr),
        .chunk_write_enable(chunk_write_enable), .row_addr(row_addr), .panel_addr(panel_addr),
        .sclk(sclk), .sdata(sdata), .latch(latch), .oe_n(oe_n), .row_sel(row_sel),
        .frame_swapped(frame_swapped)
    );

    always #5 clk = ~clk;

    // Model: bank contents plus scan position (row, phase within the row period).
    logic [31:0] mbank [2][256];
    bit          mknown [2][256];
    int          m_row, m_phase, cyc, row_bad, fm_phase, disp_run, disp_last;
    bit          m_front, m_pending, m_fs;
    logic [3:0]  m_rsel;
    logic [8:0]  fm_obs, fm_exp;
    int          total = 0;
    int          bad = 0;

    function automatic void model_init();
        m_row = 0; m_phase = 0; m_front = 0; m_pending = 0; m_fs = 0; m_rsel = 4'd0;
        row_bad = 0; cyc = 0; disp_run = 0; disp_last = 0;
    endfunction

    function automatic void expect_now(output logic [7:0] e, output logic sd, output bit sv);
        int ch, q, b;
        logic s, la, oe;
        s = 1'b0; la = 1'b0; oe = 1'b1; sd = 1'b0; sv = 0;
        if (m_phase < 16 * C) begin
            ch = m_phase / C;
            q  = m_phase % C;
            if (q >= 2) begin
                b = (q - 2) / (2 * D);
                s = ((q - 2) % (2 * D)) >= D;
                if (mknown[m_front][m_row * 16 + ch]) begin
                    sv = 1;
                    sd = mbank[m_front][m_row * 16 + ch][31 - b];
                end
            end
        end else if (m_phase < 16 * C + L) begin
            la = 1'b1;
        end else begin
            oe = 1'b0;
        end
        e = {s, la, oe, m_rsel, m_fs};
    endfunction

    function automatic void model_advance(input bit acc, input logic [7:0] a, input logic [31:0] d);
        bit fs_next;
        fs_next = 0;
        if (!(m_phase == R - 1 && m_row == 15 && m_pending && acc)) begin
            m_phase++;
            if (m_phase == 16 * C) m_rsel = 4'(m_row);
            if (m_phase == R) begin
                total++;
                if (row_bad != 0) begin
                    bad++;
                    $display("FAIL scan_row row=%0d phase=%0d errs=%0d got=%b want=%b",
                             m_row, fm_phase, row_bad, fm_obs, fm_exp);
                end
                row_bad = 0;
                m_phase = 0;
                if (m_row == 15 && m_pending) begin
                    m_front = ~m_front; m_pending = 0; fs_next = 1;
                end
                m_row = (m_row + 1) % 16;
            end
        end
        if (acc) begin
            mbank[~m_front][a] = d;
            mknown[~m_front][a] = 1;
            if (a == 8'hFF) m_pending = 1;
        end
        m_fs = fs_next;
    endfunction

    task automatic step(input bit we, input logic [1:0] pa, input logic [3:0] ra,
                        input logic [3:0] ca, input logic [31:0] d);
        logic [7:0] e, o;
        logic sd;
        bit sv;
        expect_now(e, sd, sv);
        o = {sclk, latch, oe_n, row_sel, frame_swapped};
        if (o !== e || (sv && sdata !== sd)) begin
            if (row_bad == 0) begin
                fm_phase = m_phase; fm_obs = {o, sdata}; fm_exp = {e, sv ? sd : sdata};
            end
            row_bad++;
        end
        if (oe_n === 1'b0) disp_run++;
        else if (disp_run != 0) begin disp_last = disp_run; disp_run = 0; end
        chunk_write_enable = we; panel_addr = pa; row_addr = ra; chunk_addr = ca; chunk_data = d;
        @(posedge clk); #1;
        chunk_write_enable = 1'b0;
        cyc++;
        model_advance(we && pa == 2'(PID), {ra, ca}, d);
    endtask

    task automatic test_reset();
        int n;
        n = 0;
        while (sclk !== 1'b1 && n < 50) begin step(0, 2'd0, 4'd0, 4'd0, 32'd0); n++; end
        total++;
        if (n != 2 + D) begin bad++; $display("FAIL first_sclk_rise got=%0d want=%0d", n, 2 + D); end
        total++;
        if (row_bad != 0) begin bad++; $display("FAIL pre_reset_scan errs=%0d want=0", row_bad); end
        reset_n = 1'b0;
        #2;
        total++;
        if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        total++;
        if (oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", oe_n); end
        total++;
        if (latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b want=0", latch); end
        total++;
        if ({row_sel, frame_swapped, sdata} !== 6'd0) begin
            bad++; $display("FAIL reset_misc got=%b want=000000", {row_sel, frame_swapped, sdata});
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        model_init();
        n = 0;
        while (sclk !== 1'b1 && n < 50) begin step(0, 2'd0, 4'd0, 4'd0, 32'd0); n++; end
        total++;
        if (n != 2 + D) begin bad++; $display("FAIL first_sclk_rise2 got=%0d want=%0d", n, 2 + D); end
    endtask

    task automatic test_single_row();
        int n, lat, oen, fs;
        bit rs_ok;
        logic prev;
        logic [31:0] w;
        logic bits[$];
        for (int a = 0; a < 256; a++)
            step(1, 2'(PID), 4'(a / 16), 4'(a % 16), (a < 16) ? 32'hA5A5_0000 + 32'(a) : $urandom);
        n = 0;
        while (frame_swapped !== 1'b1 && n < 32 * R) begin step(0, 2'd0, 4'd0, 4'd0, 32'd0); n++; end
        total++;
        if (cyc != 16 * R) begin bad++; $display("FAIL swap_cycle got=%0d want=%0d", cyc, 16 * R); end
        prev = 1'b0; lat = 0; oen = 0; fs = 0; rs_ok = 1;
        for (int i = 0; i < R; i++) begin
            if (sclk === 1'b1 && prev === 1'b0) bits.push_back(sdata);
            prev = sclk;
            if (latch === 1'b1) lat++;
            if (oe_n === 1'b0) begin oen++; if (row_sel !== 4'd0) rs_ok = 0; end
            if (frame_swapped === 1'b1) fs++;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        total++;
        if (bits.size() != 512) begin bad++; $display("FAIL row0_bits got=%0d want=512", bits.size()); end
        for (int k = 0; k < 16; k++) begin
            w = 32'd0;
            for (int j = 0; j < 32; j++)
                if (bits.size() > k * 32 + j) w = {w[30:0], bits[k * 32 + j]};
            total++;
            if (w !== 32'hA5A5_0000 + 32'(k)) begin
                bad++; $display("FAIL row0_word%0d got=%h want=%h", k, w, 32'hA5A5_0000 + 32'(k));
            end
        end
        total++;
        if (lat != L) begin bad++; $display("FAIL latch_width got=%0d want=%0d", lat, L); end
        total++;
        if (oen != O) begin bad++; $display("FAIL on_width got=%0d want=%0d", oen, O); end
        total++;
        if (!rs_ok) begin bad++; $display("FAIL row_sel_row0 got=nonzero want=0"); end
        total++;
        if (fs != 1) begin bad++; $display("FAIL swap_pulse_len got=%0d want=1", fs); end
    endtask

    task automatic test_panel_filter();
        int fs;
        fs = 0;
        for (int a = 0; a < 256; a++) begin
            if (frame_swapped === 1'b1) fs++;
            step(1, 2'd2, 4'(a / 16), 4'(a % 16), $urandom);
        end
        while (cyc < 32 * R + 2) begin
            if (frame_swapped === 1'b1) fs++;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        total++;
        if (fs != 0) begin bad++; $display("FAIL filtered_swap got=%0d want=0", fs); end
    endtask

    task automatic test_swap_timing();
        int fs;
        fs = 0;
        for (int a = 0; a < 255; a++) begin
            if (frame_swapped === 1'b1) fs++;
            step(1, 2'(PID), 4'(a / 16), 4'(a % 16), $urandom);
        end
        while (cyc < 39 * R + 16 * C + L + 3) begin
            if (frame_swapped === 1'b1) fs++;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        total++;
        if ({oe_n, row_sel} !== 5'b0_0111) begin
            bad++; $display("FAIL row7_display got=%b want=00111", {oe_n, row_sel});
        end
        step(1, 2'(PID), 4'd15, 4'd15, $urandom);
        while (cyc < 48 * R - 1) begin
            if (frame_swapped === 1'b1) fs++;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        total++;
        if (fs != 0) begin bad++; $display("FAIL early_swap got=%0d want=0", fs); end
        total++;
        if ({oe_n, row_sel} !== 5'b0_1111) begin
            bad++; $display("FAIL row15_last_on got=%b want=01111", {oe_n, row_sel});
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] nd, w;
        logic prev;
        logic bits[$];
        nd = $urandom;
        step(1, 2'(PID), 4'd3, 4'd5, nd);
        total++;
        if ({oe_n, frame_swapped} !== 2'b00) begin
            bad++; $display("FAIL extended_display got=%b want=00", {oe_n, frame_swapped});
        end
        step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        total++;
        if ({oe_n, frame_swapped} !== 2'b11) begin
            bad++; $display("FAIL delayed_swap got=%b want=11", {oe_n, frame_swapped});
        end
        step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        total++;
        if (disp_last != O + 1) begin bad++; $display("FAIL display_len got=%0d want=%0d", disp_last, O + 1); end
        prev = 1'b0;
        while (cyc < 52 * R + 1) begin
            if (cyc >= 51 * R + 1 && sclk === 1'b1 && prev === 1'b0) bits.push_back(sdata);
            prev = sclk;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        w = 32'd0;
        for (int j = 0; j < 32; j++)
            if (bits.size() > 160 + j) w = {w[30:0], bits[160 + j]};
        total++;
        if (w !== nd) begin bad++; $display("FAIL row3_chunk5 got=%h want=%h", w, nd); end
    endtask

    task automatic test_row_wrap();
        logic [3:0] seen[$];
        int viol;
        logic pl;
        viol = 0; pl = 1'b0;
        for (int i = 0; i < 17 * R; i++) begin
            if (latch === 1'b1 && pl === 1'b0) seen.push_back(row_sel);
            if (oe_n === 1'b0 && (latch === 1'b1 || sclk === 1'b1)) viol++;
            pl = latch;
            step(0, 2'd0, 4'd0, 4'd0, 32'd0);
        end
        total++;
        if (seen.size() != 17) begin bad++; $display("FAIL latch_count got=%0d want=17", seen.size()); end
        for (int i = 0; i < 17; i++) begin
            if (i < seen.size()) begin
                total++;
                if (seen[i] !== 4'((4 + i) % 16)) begin
                    bad++; $display("FAIL row_seq%0d got=%0d want=%0d", i, seen[i], (4 + i) % 16);
                end
            end
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL blanking got=%0d want=0", viol); end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) mknown[b][a] = 0;
        reset_n = 1'b0;
        chunk_write_enable = 1'b0; chunk_data = 32'd0; chunk_addr = 4'd0;
        row_addr = 4'd0; panel_addr = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_init();
        test_reset();
        test_single_row();
        test_panel_filter();
        test_swap_timing();
        test_simultaneous();
        test_row_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
